// File: rtl/tank_gfx_pkg.sv
// Shared tank graphics types, sprite geometry and the 16-entry tank palette.
// Pure declarations; no logic, no latency.
package tank_gfx_pkg;

  localparam int SPRITE_W        = 50;
  localparam int ADDR_W          = 19;
  localparam int TRANSPARENT_IDX = 0;

  typedef logic [23:0] rgb_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  // Entry 0 is the see-through index and never reaches the screen.
  localparam rgb_t PALETTE [16] = '{
    24'h000000, 24'hFFFFFF, 24'h2E4A1E, 24'h4F7A2F,
    24'h6B8E23, 24'h8FBC3F, 24'h3B3B3B, 24'h707070,
    24'hA0A0A0, 24'h5C4033, 24'h8B5A2B, 24'hC8A165,
    24'hB22222, 24'hFFD700, 24'h1E90FF, 24'h000080
  };

  // Row stride of the 50-wide sprite as a shift-add: 50 = 32 + 16 + 2.
  function automatic logic [11:0] mul50(input logic [11:0] v);
    return (v << 5) + (v << 4) + (v << 1);
  endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// Sprite hit test, rotation and RAM address for one draw coordinate.
// Purely combinational, zero latency; no backpressure (pixel-clock stream).
module sprite_addr_gen #(
  parameter int SPRITE_W = 50,
  parameter int ADDR_W   = 19
) (
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic              blank_n,
  input  logic [9:0]        lx0,
  input  logic [9:0]        ly0,
  input  logic [1:0]        dir,
  output logic              hit,
  output logic [ADDR_W-1:0] addr
);
  import tank_gfx_pkg::*;

  logic signed [10:0] dx;
  logic signed [10:0] dy;
  logic               in_x;
  logic               in_y;
  logic [5:0]         last;
  logic [5:0]         u;
  logic [5:0]         v;
  logic [11:0]        addr12;

  // Zero-extended signed difference: a draw position left of or above the
  // tank goes negative instead of wrapping into range.
  assign dx = $signed({1'b0, draw_x}) - $signed({1'b0, lx0});
  assign dy = $signed({1'b0, draw_y}) - $signed({1'b0, ly0});

  assign in_x = !dx[10] && (dx[9:0] < 10'(SPRITE_W));
  assign in_y = !dy[10] && (dy[9:0] < 10'(SPRITE_W));
  assign hit  = blank_n && in_x && in_y;

  assign last = 6'(SPRITE_W - 1);

  always_comb begin
    u = dx[5:0];
    v = dy[5:0];
    case (dir_t'(dir))
      DIR_UP:    begin u = dx[5:0];        v = dy[5:0];        end
      DIR_RIGHT: begin u = dy[5:0];        v = last - dx[5:0]; end
      DIR_DOWN:  begin u = last - dx[5:0]; v = last - dy[5:0]; end
      DIR_LEFT:  begin u = last - dy[5:0]; v = dx[5:0];        end
    endcase
  end

  assign addr12 = mul50({6'b0, v}) + {6'b0, u};
  assign addr   = hit ? ADDR_W'(addr12) : '0;

endmodule

// File: rtl/tank_sprite_renderer.sv
// Tank sprite pixel stage around the sprite RAM: address out, palette RGB back.
// Latency 3 Clk edges from DrawX/DrawY to outputs; no backpressure (pixel-clock stream).
module tank_sprite_renderer #(
  parameter int SPRITE_W        = tank_gfx_pkg::SPRITE_W,
  parameter int ADDR_W          = tank_gfx_pkg::ADDR_W,
  parameter int TRANSPARENT_IDX = tank_gfx_pkg::TRANSPARENT_IDX
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank_n,
  input  logic              frame_start,
  input  logic [9:0]        TankX,
  input  logic [9:0]        TankY,
  input  logic [1:0]        TankDir,
  output logic [ADDR_W-1:0] read_address,
  input  logic [4:0]        sprite_data,
  output logic              tank_on,
  output logic [23:0]       tank_rgb,
  output logic              pix_valid
);
  import tank_gfx_pkg::*;

  logic [9:0]        lx0;
  logic [9:0]        ly0;
  dir_t              dir_l;
  logic              hit_s0;
  logic [ADDR_W-1:0] addr_s0;
  logic              hit_d1;
  logic              blank_d1;
  logic              hit_d2;
  logic              blank_d2;
  logic [3:0]        pal_idx;
  logic              opaque;
  logic              unused_data_msb;

  sprite_addr_gen #(
    .SPRITE_W (SPRITE_W),
    .ADDR_W   (ADDR_W)
  ) u_addr_gen (
    .draw_x  (DrawX),
    .draw_y  (DrawY),
    .blank_n (blank_n),
    .lx0     (lx0),
    .ly0     (ly0),
    .dir     (dir_l),
    .hit     (hit_s0),
    .addr    (addr_s0)
  );

  assign pal_idx         = sprite_data[3:0];
  assign unused_data_msb = sprite_data[4];
  assign opaque          = hit_d2 && (pal_idx != 4'(TRANSPARENT_IDX));

  // Tank state is only sampled at frame start so a sprite never tears;
  // a pixel drawn in the latch cycle still sees the previous frame's copy.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      lx0   <= '0;
      ly0   <= '0;
      dir_l <= DIR_UP;
    end else if (frame_start) begin
      lx0   <= TankX;
      ly0   <= TankY;
      dir_l <= dir_t'(TankDir);
    end
  end

  // hit/blank ride alongside the RAM's one-cycle read so they meet
  // sprite_data in the same cycle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      read_address <= '0;
      hit_d1       <= 1'b0;
      blank_d1     <= 1'b0;
      hit_d2       <= 1'b0;
      blank_d2     <= 1'b0;
      tank_on      <= 1'b0;
      tank_rgb     <= '0;
      pix_valid    <= 1'b0;
    end else begin
      read_address <= addr_s0;
      hit_d1       <= hit_s0;
      blank_d1     <= blank_n;
      hit_d2       <= hit_d1;
      blank_d2     <= blank_d1;
      tank_on      <= opaque;
      tank_rgb     <= opaque ? PALETTE[pal_idx] : 24'h0;
      pix_valid    <= blank_d2;
    end
  end

endmodule

// File: tb/tb_tank_sprite_renderer.sv
// Directed bench for tank_sprite_renderer with a registered sprite RAM model
// and a queue of expected pixels checked three edges after each drive.
module tb_tank_sprite_renderer;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        blank_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [9:0]  TankX = 10'd17;
  logic [9:0]  TankY = 10'd33;
  logic [1:0]  TankDir = 2'd2;
  logic [18:0] read_address;
  logic [4:0]  sprite_data = '0;
  logic        tank_on;
  logic [23:0] tank_rgb;
  logic        pix_valid;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        on;
    logic [23:0] rgb;
    logic        pv;
  } exp_t;

  exp_t out_q[$];
  int   m_lx = 0;
  int   m_ly = 0;
  int   m_dir = 0;

  localparam logic [23:0] PAL [16] = '{
    24'h000000, 24'hFFFFFF, 24'h2E4A1E, 24'h4F7A2F,
    24'h6B8E23, 24'h8FBC3F, 24'h3B3B3B, 24'h707070,
    24'hA0A0A0, 24'h5C4033, 24'h8B5A2B, 24'hC8A165,
    24'hB22222, 24'hFFD700, 24'h1E90FF, 24'h000080
  };

  tank_sprite_renderer dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .blank_n      (blank_n),
    .frame_start  (frame_start),
    .TankX        (TankX),
    .TankY        (TankY),
    .TankDir      (TankDir),
    .read_address (read_address),
    .sprite_data  (sprite_data),
    .tank_on      (tank_on),
    .tank_rgb     (tank_rgb),
    .pix_valid    (pix_valid)
  );

  always #5 Clk = ~Clk;

  // Sprite RAM: one-cycle registered read; bit 4 carries junk that must be ignored.
  always @(posedge Clk) sprite_data <= {read_address[4], read_address[3:0] ^ 4'h2};

  function automatic logic [3:0] mem_idx(input int a);
    logic [11:0] t;
    t = 12'(a);
    return t[3:0] ^ 4'h2;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic flush_pipe();
    exp_t z;
    z = '0;
    out_q.delete();
    out_q.push_back(z);
    out_q.push_back(z);
  endtask

  task automatic step(input int x, input int y, input logic bl, input logic fs);
    int   dx, dy, u, v, a;
    logic hit;
    exp_t e;
    @(negedge Clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank_n = bl;
    frame_start = fs;
    dx = x - m_lx;
    dy = y - m_ly;
    hit = bl && (dx >= 0) && (dx < 50) && (dy >= 0) && (dy < 50);
    case (m_dir)
      0:       begin u = dx;      v = dy;      end
      1:       begin u = dy;      v = 49 - dx; end
      2:       begin u = 49 - dx; v = 49 - dy; end
      default: begin u = 49 - dy; v = dx;      end
    endcase
    a = hit ? (v * 50 + u) : 0;
    e.on  = hit && (mem_idx(a) != 4'h0);
    e.rgb = e.on ? PAL[mem_idx(a)] : 24'h0;
    e.pv  = bl;
    out_q.push_back(e);
    if (fs) begin
      m_lx = int'(TankX);
      m_ly = int'(TankY);
      m_dir = int'(TankDir);
    end
    @(posedge Clk);
    #1;
    check("read_address", 32'(read_address), 32'(a));
    e = out_q.pop_front();
    check("tank_on", 32'(tank_on), 32'(e.on));
    check("tank_rgb", 32'(tank_rgb), 32'(e.rgb));
    check("pix_valid", 32'(pix_valid), 32'(e.pv));
    frame_start = 1'b0;
  endtask

  initial begin
    // Reset state with nonzero inputs applied
    DrawX = 10'd120; DrawY = 10'd210; blank_n = 1'b1;
    #3;
    check("rst_addr", 32'(read_address), 32'd0);
    check("rst_on", 32'(tank_on), 32'd0);
    check("rst_rgb", 32'(tank_rgb), 32'd0);
    check("rst_pv", 32'(pix_valid), 32'd0);
    @(posedge Clk);
    #2 Reset_n = 1'b1;
    flush_pipe();

    // Direction 0 at (100,200)
    TankX = 10'd100; TankY = 10'd200; TankDir = 2'd0;
    step(0, 0, 1'b0, 1'b1);
    step(103, 202, 1'b1, 1'b0);
    check("addr_dir0", 32'(read_address), 32'd103);
    step(102, 200, 1'b1, 1'b0);
    step(99, 202, 1'b1, 1'b0);
    step(150, 202, 1'b1, 1'b0);
    step(103, 202, 1'b0, 1'b0);
    step(149, 249, 1'b1, 1'b0);
    check("addr_max", 32'(read_address), 32'd2499);

    // Rotations
    TankDir = 2'd1;
    step(0, 0, 1'b0, 1'b1);
    step(100, 200, 1'b1, 1'b0);
    check("addr_dir1", 32'(read_address), 32'd2450);
    TankDir = 2'd2;
    step(0, 0, 1'b0, 1'b1);
    step(149, 249, 1'b1, 1'b0);
    step(120, 210, 1'b1, 1'b0);
    TankDir = 2'd3;
    step(0, 0, 1'b0, 1'b1);
    step(100, 249, 1'b1, 1'b0);
    step(110, 205, 1'b1, 1'b0);
    check("addr_dir3", 32'(read_address), 32'd544);

    // Live state changes without frame_start are ignored
    TankDir = 2'd0;
    step(0, 0, 1'b0, 1'b1);
    TankX = 10'd300;
    step(100, 200, 1'b1, 1'b0);
    step(300, 200, 1'b1, 1'b0);
    step(100, 200, 1'b1, 1'b1);
    step(300, 200, 1'b1, 1'b0);
    step(100, 200, 1'b1, 1'b0);

    // Sprite hanging off the right edge: no wrap to column 0
    TankX = 10'd620;
    step(0, 0, 1'b0, 1'b1);
    step(639, 210, 1'b1, 1'b0);
    step(0, 210, 1'b1, 1'b0);
    step(5, 210, 1'b1, 1'b0);
    step(0, 0, 1'b0, 1'b0);
    step(0, 0, 1'b0, 1'b0);

    // Mid-line asynchronous reset
    TankX = 10'd100;
    step(0, 0, 1'b0, 1'b1);
    step(103, 202, 1'b1, 1'b0);
    step(104, 202, 1'b1, 1'b0);
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    check("mid_rst_addr", 32'(read_address), 32'd0);
    check("mid_rst_on", 32'(tank_on), 32'd0);
    check("mid_rst_rgb", 32'(tank_rgb), 32'd0);
    check("mid_rst_pv", 32'(pix_valid), 32'd0);
    m_lx = 0; m_ly = 0; m_dir = 0;
    @(posedge Clk);
    #2 Reset_n = 1'b1;
    flush_pipe();
    step(5, 5, 1'b1, 1'b0);
    step(6, 5, 1'b1, 1'b0);
    step(7, 5, 1'b1, 1'b0);
    step(0, 0, 1'b0, 1'b0);
    step(0, 0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tank_sprite_renderer.md
Name: tank_sprite_renderer

Overview:
- Pixel-pipeline stage directly upstream and downstream of the 50x50 tank sprite frame RAM.
- Takes the VGA draw coordinate and latches tank state, computes the sprite RAM read address with rotation, and receives the 4-bit palette index one cycle later.
- Resolves transparency and palette, and emits a registered RGB pixel plus coverage flag to the colour mapper.
- Tank position and direction are sampled once per frame so the sprite never tears mid-frame.

Parameters:
- SPRITE_W, 50, sprite width and height in pixels (square sprite).
- ADDR_W, 19, width of the sprite RAM address bus.
- TRANSPARENT_IDX, 0, palette index treated as see-through.

Ports:
- Clk  in  1  pixel clock.
- Reset_n  in  1  asynchronous, active-low reset.
- DrawX  in  10  current pixel column from the VGA controller.
- DrawY  in  10  current pixel row from the VGA controller.
- blank_n  in  1  1 = visible pixel region.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- TankX  in  10  tank top-left column (live game state).
- TankY  in  10  tank top-left row.
- TankDir  in  2  0 up, 1 right, 2 down, 3 left.
- read_address  out  ADDR_W  address to the sprite RAM.
- sprite_data  in  5  sprite RAM data_Out; only bits [3:0] are used.
- tank_on  out  1  1 = opaque tank pixel at the aligned coordinate.
- tank_rgb  out  24  {R,G,B} 8 bits each; 0 when tank_on = 0.
- pix_valid  out  1  blank_n delayed to align with tank_on/tank_rgb.

Behaviour:
- Reset (async, Reset_n = 0): all outputs and all pipeline registers are 0. Latched X, Y and Dir are 0.
- Frame latch:
  - On a Clk edge with frame_start = 1, register TankX/TankY/TankDir into latched copies (lx0, ly0, dir_l).
  - Those copies are used for the entire following frame.
- S0 (cycle n), combinational from DrawX/DrawY and the latched state:
  - dx = DrawX - lx0, dy = DrawY - ly0, each 11-bit signed.
  - hit = blank_n and 0 <= dx < SPRITE_W and 0 <= dy < SPRITE_W.
  - Rotated coordinates (u,v):
    - dir 0: (dx, dy)
    - dir 1: (dy, 49-dx)
    - dir 2: (49-dx, 49-dy)
    - dir 3: (49-dy, dx)
  - Address = v*50 + u, computed as (v<<5)+(v<<4)+(v<<1)+u with no multiplier inferred. Maximum value is 2499.
  - read_address is registered at the end of S0. When hit = 0, read_address is 0.
  - hit_d1 and blank_d1 are registered alongside.
- S1 (cycle n+1): the RAM registers data for read_address. Register hit_d2 and blank_d2 so they align with sprite_data at the end of n+1.
- S2 (cycle n+2), registered outputs:
  - tank_on = hit_d2 and (sprite_data[3:0] != TRANSPARENT_IDX).
  - tank_rgb = PALETTE[sprite_data[3:0]] if tank_on, else 24'h0.
  - pix_valid = blank_d2.
  - Total latency from DrawX/DrawY to outputs is 3 Clk edges. The colour mapper delays DrawX/DrawY by the same amount.
- Boundaries:
  - Sprite partly off-screen (lx0 near 640): only in-range dx pixels hit; no wrap onto column 0.
  - Subtraction is signed, so DrawX < lx0 gives dx negative, which is a miss.
  - frame_start and a visible pixel in the same cycle: the pixel uses the old latched values, and the new values take effect next cycle.
  - blank_n = 0 forces hit = 0 regardless of coordinate.
  - sprite_data[4] is ignored.
  - Reset asserted mid-line clears the pipeline immediately. After release, the first 2 output cycles are tank_on = 0.

Decomposition:
- Package tank_gfx_pkg:
  - SPRITE_W, TRANSPARENT_IDX.
  - typedef rgb_t (24-bit) and typedef dir_t enum {DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT}.
  - constant PALETTE: array of 16 rgb_t, with entry 0 = 24'h000000 (unused, transparent).
- Sub-module sprite_addr_gen: combinational dx/dy, hit, rotation and address; the top holds all registers.

Test Plan:
- Reset_n low mid-frame with nonzero inputs -> tank_on = 0, tank_rgb = 0, read_address = 0 asynchronously; outputs stay 0 for 2 cycles after release.
- Latch TankX = 100, TankY = 200, Dir = 0; drive DrawX = 103, DrawY = 202 -> read_address = 103 one cycle later. With RAM model index 5, tank_on = 1 and tank_rgb = PALETTE[5] three edges after input.
- Dir = 1, same position, DrawX = 100, DrawY = 200 (dx = 0, dy = 0) -> (u,v) = (0,49), read_address = 2450.
- Dir = 2, DrawX = 149, DrawY = 249 -> read_address = 0. Dir = 3, DrawX = 100, DrawY = 249 -> read_address = 0.
- RAM returns index 0 inside the box -> tank_on = 0, tank_rgb = 0. DrawX = 99 or 150 -> miss. blank_n = 0 inside the box -> miss, pix_valid = 0.
- Change TankX from 100 to 300 mid-frame without frame_start -> rendering stays at 100. Pulse frame_start together with a pixel at DrawX = 100 -> that pixel still hits, and the next frame renders at 300.
